// File: rtl/si5340_i2c_target.sv
// Si5340-style I2C target: 7-bit address, 16-bit register pointer, 8-bit register file.
// Define SI5340_TARGET_AUTOINC_EN to advance the pointer after each data write / ACKed read.
module si5340_i2c_target #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h74,
  parameter int unsigned REG_DEPTH  = 256,
  parameter string       INIT_MEM   = "",
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        scl_pad_i,
  output logic        scl_pad_o,
  output logic        scl_padoen_o,
  input  logic        sda_pad_i,
  output logic        sda_pad_o,
  output logic        sda_padoen_o,
  output logic        wr_strb_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        busy_o
);

  localparam int unsigned IdxW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

`ifdef SI5340_TARGET_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StRx, StRxAck, StTx, StTxAck, StIgnore
  } state_e;

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0]      sync0_q, sync1_q, filt_q, last_q;
  logic [CntW-1:0] cnt_q [2];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync0_q <= '1;
      sync1_q <= '1;
      filt_q  <= '1;
      last_q  <= '1;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync0_q <= {sda_pad_i, scl_pad_i};
      sync1_q <= sync0_q;
      last_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync1_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync1_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic sda, scl_rise, scl_fall, scl_hi, start_det, stop_det;
  assign sda       = filt_q[1];
  assign scl_rise  = filt_q[0] & ~last_q[0];
  assign scl_fall  = ~filt_q[0] & last_q[0];
  // SCL must be high on both samples so a simultaneous SCL edge never reads as START/STOP.
  assign scl_hi    = filt_q[0] & last_q[0];
  assign start_det = scl_hi & ~filt_q[1] & last_q[1];
  assign stop_det  = scl_hi & filt_q[1] & ~last_q[1];

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic        ack_q, ack_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] ptr_q, ptr_d, ptr_next;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        wr_strb_q, wr_strb_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        mem_we;
  logic [7:0]  rx_byte, mem_rdata;
  logic [7:0]  mem_q [REG_DEPTH];

  assign rx_byte   = {shift_q[6:0], sda};
  assign mem_rdata = mem_q[ptr_q[IdxW-1:0]];
  assign ptr_next  = AutoInc ? ptr_q + 16'd1 : ptr_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    byte_idx_d = byte_idx_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_strb_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b1;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b1;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ack_d   = 1'b0;
            rw_d    = sda;
            state_d = (rx_byte[7:1] == SLAVE_ADDR) ? StAddrAck : StIgnore;
          end
        end
        // Ack states see two falling edges: the first starts the ACK slot, the second ends it.
        StAddrAck: if (scl_fall) begin
          if (!ack_q) begin
            sda_oe_d = 1'b0;
            ack_d    = 1'b1;
          end else begin
            bit_cnt_d = '0;
            if (rw_q) begin
              shift_d  = mem_rdata;
              sda_oe_d = mem_rdata[7];
              state_d  = StTx;
            end else begin
              sda_oe_d   = 1'b1;
              byte_idx_d = '0;
              state_d    = StRx;
            end
          end
        end
        StRx: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ack_d   = 1'b0;
            state_d = StRxAck;
            unique case (byte_idx_q)
              2'd0: begin
                ptr_d[15:8] = rx_byte;
                byte_idx_d  = 2'd1;
              end
              2'd1: begin
                ptr_d[7:0] = rx_byte;
                byte_idx_d = 2'd2;
              end
              default: begin
                mem_we    = 1'b1;
                wr_strb_d = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_byte;
                ptr_d     = ptr_next;
              end
            endcase
          end
        end
        StRxAck: if (scl_fall) begin
          if (!ack_q) begin
            sda_oe_d = 1'b0;
            ack_d    = 1'b1;
          end else begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = '0;
            state_d   = StRx;
          end
        end
        StTx: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_d   = 1'b0;
              state_d = StTxAck;
            end
          end else if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = shift_q[6];
          end
        end
        StTxAck: begin
          if (scl_fall) begin
            if (!ack_q) begin
              sda_oe_d = 1'b1;
              ack_d    = 1'b1;
            end else begin
              shift_d   = mem_rdata;
              sda_oe_d  = mem_rdata[7];
              bit_cnt_d = '0;
              state_d   = StTx;
            end
          end else if (scl_rise && ack_q) begin
            if (sda) state_d = StIgnore;
            else ptr_d = ptr_next;
          end
        end
        StIdle, StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      byte_idx_q <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b1;
      busy_q     <= 1'b0;
      wr_strb_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      byte_idx_q <= byte_idx_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_strb_q  <= wr_strb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Register contents survive reset; only the bus engine is cleared.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[ptr_q[IdxW-1:0]] <= rx_byte;
  end

  initial begin
    for (int i = 0; i < REG_DEPTH; i++) mem_q[i] = 8'h00;
  end

  assign scl_pad_o    = 1'b0;
  assign scl_padoen_o = 1'b1;
  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = sda_oe_q;
  assign wr_strb_o    = wr_strb_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_si5340_i2c_target.sv
// Bench for si5340_i2c_target: bit-banged I2C master plus a transaction-level register model.
module tb_si5340_i2c_target;

  localparam int Q = 10;  // quarter SCL period in clk cycles

`ifdef SI5340_TARGET_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_line;
  logic        scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
  logic        wr_strb_o, busy_o;
  logic [15:0] wr_addr_o;
  logic [7:0]  wr_data_o;

  assign sda_line = m_sda & (sda_padoen_o | sda_pad_o);

  si5340_i2c_target dut (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .scl_pad_i    (m_scl),
    .scl_pad_o    (scl_pad_o),
    .scl_padoen_o (scl_padoen_o),
    .sda_pad_i    (sda_line),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .wr_strb_o    (wr_strb_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int strb_cnt = 0;
  int pull_cnt = 0;

  always @(negedge clk_i) begin
    if (wr_strb_o) strb_cnt++;
    if (!sda_padoen_o) pull_cnt++;
  end

  logic [7:0]  ref_mem [256];
  logic [15:0] ref_ptr = '0;
  logic [15:0] ref_waddr = '0;
  logic [7:0]  ref_wdata = '0;
  logic [7:0]  wbuf [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic q_wait(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic bus_start;
    m_sda = 1'b1; q_wait(Q);
    m_scl = 1'b1; q_wait(Q);
    m_sda = 1'b0; q_wait(Q);
    m_scl = 1'b0; q_wait(Q);
  endtask

  task automatic bus_stop;
    m_sda = 1'b0; q_wait(Q);
    m_scl = 1'b1; q_wait(Q);
    m_sda = 1'b1; q_wait(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    q_wait(Q);
    m_scl = 1'b1; q_wait(2 * Q);
    m_scl = 1'b0; q_wait(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; q_wait(Q);
    m_scl = 1'b1; q_wait(Q);
    ack = sda_line; q_wait(Q);
    m_scl = 1'b0; q_wait(Q);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      q_wait(Q); m_scl = 1'b1;
      q_wait(Q); b[i] = sda_line;
      q_wait(Q); m_scl = 1'b0;
      q_wait(Q);
    end
    send_bit(mack);
  endtask

  // Write transaction of wbuf: first two bytes set the pointer, the rest are data.
  task automatic wr_txn(input string tag);
    logic ack;
    int   s0, exp_strb;
    s0 = strb_cnt;
    exp_strb = 0;
    bus_start;
    send_byte(8'hE8, ack);
    check({tag, ".aack"}, ack, 0);
    for (int i = 0; i < wbuf.size(); i++) begin
      send_byte(wbuf[i], ack);
      check({tag, ".dack"}, ack, 0);
      if (i == 0) ref_ptr[15:8] = wbuf[i];
      else if (i == 1) ref_ptr[7:0] = wbuf[i];
      else begin
        ref_mem[ref_ptr[7:0]] = wbuf[i];
        ref_waddr = ref_ptr;
        ref_wdata = wbuf[i];
        exp_strb++;
        if (AutoInc) ref_ptr = ref_ptr + 16'd1;
      end
    end
    bus_stop;
    q_wait(4);
    check({tag, ".strb"}, strb_cnt - s0, exp_strb);
    check({tag, ".waddr"}, wr_addr_o, ref_waddr);
    check({tag, ".wdata"}, wr_data_o, ref_wdata);
    check({tag, ".busy"}, busy_o, 0);
  endtask

  // Set pointer, repeated START, read n bytes (NACK on the last).
  task automatic rd_txn(input string tag, input logic [15:0] p, input int n);
    logic       ack;
    logic [7:0] b;
    int         s0;
    s0 = strb_cnt;
    bus_start;
    send_byte(8'hE8, ack);
    check({tag, ".aack"}, ack, 0);
    send_byte(p[15:8], ack);
    send_byte(p[7:0], ack);
    check({tag, ".pack"}, ack, 0);
    ref_ptr = p;
    bus_start;
    send_byte(8'hE9, ack);
    check({tag, ".rack"}, ack, 0);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, b);
      check({tag, ".rdata"}, b, ref_mem[ref_ptr[7:0]]);
      if (k != n - 1 && AutoInc) ref_ptr = ref_ptr + 16'd1;
    end
    bus_stop;
    q_wait(4);
    check({tag, ".nostrb"}, strb_cnt - s0, 0);
    check({tag, ".busy"}, busy_o, 0);
  endtask

  initial begin
    logic       ack;
    int         s0, p0, n;
    logic [15:0] rp;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    q_wait(3);
    check("rst.oe", sda_padoen_o, 1);
    check("rst.busy", busy_o, 0);
    check("rst.strb", wr_strb_o, 0);
    check("rst.waddr", wr_addr_o, 0);
    check("rst.wdata", wr_data_o, 0);
    check("rst.sclpad", {scl_pad_o, scl_padoen_o, sda_pad_o}, 3'b010);
    arstn_i = 1'b1;
    q_wait(10);

    // Single register write, then read it back through a repeated START.
    wbuf = '{8'h00, 8'h12, 8'h5A};
    wr_txn("t1");
    check("t1.addr_const", wr_addr_o, 16'h0012);
    check("t1.data_const", wr_data_o, 8'h5A);
    rd_txn("t2", 16'h0012, 1);

    // Address mismatch: target must stay silent and write nothing.
    s0 = strb_cnt;
    p0 = pull_cnt;
    bus_start;
    check("t3.busy_in", busy_o, 1);
    send_byte(8'hEA, ack);
    check("t3.nack", ack, 1);
    send_byte(8'h00, ack);
    send_byte(8'h12, ack);
    send_byte(8'h77, ack);
    check("t3.dnack", ack, 1);
    bus_stop;
    q_wait(4);
    check("t3.nopull", pull_cnt - p0, 0);
    check("t3.nostrb", strb_cnt - s0, 0);
    check("t3.busy", busy_o, 0);

    // Burst across the 0xFF -> 0x00 index boundary.
    wbuf = '{8'h00, 8'hFF, 8'h11, 8'h22};
    wr_txn("t4");
    rd_txn("t4r", 16'h00FF, 2);

    // One-cycle SDA glitches: neither a false START in idle nor a false STOP mid-transfer.
    m_sda = 1'b0; q_wait(1); m_sda = 1'b1;
    q_wait(12);
    check("t5.idle", busy_o, 0);
    bus_start;
    m_sda = 1'b0; q_wait(Q);
    m_scl = 1'b1; q_wait(Q);
    m_sda = 1'b1; q_wait(1); m_sda = 1'b0;
    q_wait(Q);
    check("t5.nostop", busy_o, 1);
    m_sda = 1'b1; q_wait(Q);
    check("t5.stop", busy_o, 0);

    // Reset during the 5th bit of a data byte.
    s0 = strb_cnt;
    bus_start;
    send_byte(8'hE8, ack);
    send_byte(8'h00, ack);
    send_byte(8'h34, ack);
    for (int i = 7; i > 3; i--) send_bit(i[0]);
    m_sda = 1'b0; q_wait(Q);
    m_scl = 1'b1; q_wait(Q);
    arstn_i = 1'b0;
    #1;
    check("t6.oe", sda_padoen_o, 1);
    check("t6.busy", busy_o, 0);
    q_wait(2);
    arstn_i = 1'b1;
    m_scl = 1'b0; q_wait(Q);
    bus_stop;
    q_wait(4);
    check("t6.nostrb", strb_cnt - s0, 0);
    ref_ptr = '0;
    ref_waddr = '0;
    ref_wdata = '0;
    check("t6.waddr", wr_addr_o, 0);
    wbuf = '{8'h00, 8'h34, 8'hA5};
    wr_txn("t6w");
    rd_txn("t6r", 16'h0034, 1);

    // Randomized write/readback against the model.
    for (int r = 0; r < 6; r++) begin
      rp = 16'($urandom);
      n = int'($urandom_range(1, 3));
      wbuf = '{rp[15:8], rp[7:0]};
      for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom));
      wr_txn("rnd.w");
      rd_txn("rnd.r", rp, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
